// File: rtl/cam_init_seq.sv
// Camera sensor power-up and register-init sequencer: reset pin timing, then table walk to IIC.
// Define CAM_INIT_READBACK_EN to verify every write with a read of the same register.
module cam_init_seq #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned RST_LOW_MS    = 10,
    parameter int unsigned RST_SETTLE_MS = 20,
    parameter int unsigned TBL_AW        = 8,
    parameter logic [6:0]  DEV_ADDR      = 7'h36,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              start,
    output logic              mipi_rst,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [25:0]       tbl_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [6:0]        cmd_dev,
    output logic [15:0]       cmd_reg,
    output logic [7:0]        cmd_data,
    input  logic              rsp_valid,
    input  logic              rsp_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [TBL_AW-1:0] err_idx
`ifdef CAM_INIT_READBACK_EN
    ,
    output logic              cmd_rd,
    input  logic [7:0]        rsp_data
`endif
);

    localparam int unsigned TICK = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [TBL_AW-1:0] LAST = {TBL_AW{1'b1}};

    typedef enum logic [3:0] {
        StIdle, StRstLow, StRstSettle, StFetch, StFetchWait,
        StIssue, StWaitRsp, StDelay, StNext, StDone, StError
    } state_t;

    state_t            state;
    logic [TBL_AW-1:0] idx;
    logic [PW-1:0]     pre;
    logic [15:0]       ms_cnt;
    logic [15:0]       ms_target;
    logic [7:0]        retry;
    logic              tick;
    logic              ms_done;
    logic              rsp_fail;

    assign cmd_dev  = DEV_ADDR;
    assign tbl_addr = idx;
    assign tick     = (pre == PW'(TICK - 1));
    assign ms_done  = tick && (({1'b0, ms_cnt} + 17'd1) >= {1'b0, ms_target});

`ifdef CAM_INIT_READBACK_EN
    assign rsp_fail = rsp_nack || (cmd_rd && (rsp_data != cmd_data));
`else
    assign rsp_fail = rsp_nack;
`endif

    // DELAY entries reuse cmd_reg as their ms count; cmd_valid is low meanwhile.
    always_comb begin
        ms_target = cmd_reg;
        if (state == StRstLow) begin
            ms_target = 16'(RST_LOW_MS);
        end else if (state == StRstSettle) begin
            ms_target = 16'(RST_SETTLE_MS);
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            idx       <= '0;
            pre       <= '0;
            ms_cnt    <= '0;
            retry     <= '0;
            mipi_rst  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_reg   <= '0;
            cmd_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= '0;
            err_idx   <= '0;
`ifdef CAM_INIT_READBACK_EN
            cmd_rd    <= 1'b0;
`endif
        end else begin
            if (state == StRstLow || state == StRstSettle || state == StDelay) begin
                pre <= tick ? '0 : pre + PW'(1);
                if (tick && ms_cnt != 16'hFFFF) begin
                    ms_cnt <= ms_cnt + 16'd1;
                end
            end
            case (state)
                StIdle, StDone, StError: begin
                    if (start) begin
                        state    <= StRstLow;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        err_code <= '0;
                        idx      <= '0;
                        mipi_rst <= 1'b0;
                        pre      <= '0;
                        ms_cnt   <= '0;
                    end
                end
                StRstLow: begin
                    if (ms_done) begin
                        mipi_rst <= 1'b1;
                        ms_cnt   <= '0;
                        state    <= StRstSettle;
                    end
                end
                StRstSettle: begin
                    if (ms_done) begin
                        state <= StFetch;
                    end
                end
                StFetch: state <= StFetchWait;
                StFetchWait: begin
                    cmd_reg  <= tbl_data[23:8];
                    cmd_data <= tbl_data[7:0];
                    case (tbl_data[25:24])
                        2'b00: begin
                            retry     <= '0;
                            cmd_valid <= 1'b1;
                            state     <= StIssue;
`ifdef CAM_INIT_READBACK_EN
                            cmd_rd    <= 1'b0;
`endif
                        end
                        2'b01: begin
                            pre    <= '0;
                            ms_cnt <= '0;
                            state  <= (tbl_data[23:8] == 16'd0) ? StNext : StDelay;
                        end
                        2'b10: begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                        default: begin
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= 2'd3;
                            err_idx  <= idx;
                            state    <= StError;
                        end
                    endcase
                end
                StIssue: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (rsp_valid) begin
                        if (rsp_fail) begin
                            if (retry < 8'(MAX_RETRY)) begin
                                // A failed readback also reissues the write, not just the read.
                                retry     <= retry + 8'd1;
                                cmd_valid <= 1'b1;
                                state     <= StIssue;
`ifdef CAM_INIT_READBACK_EN
                                cmd_rd    <= 1'b0;
`endif
                            end else begin
                                busy     <= 1'b0;
                                error    <= 1'b1;
                                err_code <= 2'd1;
                                err_idx  <= idx;
                                state    <= StError;
                            end
`ifdef CAM_INIT_READBACK_EN
                        end else if (!cmd_rd) begin
                            cmd_rd    <= 1'b1;
                            cmd_valid <= 1'b1;
                            state     <= StIssue;
                        end else begin
                            cmd_rd <= 1'b0;
                            state  <= StNext;
                        end
`else
                        end else begin
                            state <= StNext;
                        end
`endif
                    end
                end
                // The delay end advances the index itself so the wait is not stretched.
                StDelay, StNext: begin
                    if (state == StNext || ms_done) begin
                        if (idx == LAST) begin
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= 2'd2;
                            err_idx  <= idx;
                            state    <= StError;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= StFetch;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_init_seq.sv
// Scoreboard bench for cam_init_seq: ROM model, IIC master model with stall/NACK injection.
module tb_cam_init_seq;

    // CLK_HZ of 1 MHz gives a 1000-cycle ms tick, keeping the runs short.
    localparam int unsigned TBL_AW = 2;

    logic              clk_50m = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mipi_rst;
    logic [TBL_AW-1:0] tbl_addr;
    logic [25:0]       tbl_data = '0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [6:0]        cmd_dev;
    logic [15:0]       cmd_reg;
    logic [7:0]        cmd_data;
    logic              rsp_valid = 1'b0;
    logic              rsp_nack = 1'b0;
    logic              busy, done, error;
    logic [1:0]        err_code;
    logic [TBL_AW-1:0] err_idx;

    cam_init_seq #(
        .CLK_HZ(1000000), .RST_LOW_MS(1), .RST_SETTLE_MS(1),
        .TBL_AW(TBL_AW), .DEV_ADDR(7'h36), .MAX_RETRY(3)
    ) dut (
        .clk_50m(clk_50m), .rst(rst), .start(start), .mipi_rst(mipi_rst),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .err_idx(err_idx)
    );

    always #5 clk_50m = ~clk_50m;

    logic [25:0] rom [4];
    always @(posedge clk_50m) tbl_data <= rom[tbl_addr];

    int checks = 0;
    int failures = 0;
    logic [30:0] exp_q [$];
    int hs_count = 0;
    int stall_cycles = 0;
    int stab_bad = 0;
    int ready_delay = 0;
    int ack_skip = 0;
    int nack_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] wr(input logic [15:0] r, input logic [7:0] v);
        return {2'b00, r, v};
    endfunction
    function automatic logic [25:0] dly(input logic [15:0] ms);
        return {2'b01, ms, 8'h00};
    endfunction
    localparam logic [25:0] END_E = {2'b10, 24'h0};
    localparam logic [25:0] RSV_E = {2'b11, 24'h0};

    function automatic logic [30:0] exp_cmd(input logic [25:0] e);
        return {7'h36, e[23:0]};
    endfunction

    // IIC master model: grants after ready_delay cycles, responds 4 cycles after acceptance.
    int wait_cnt = 0;
    int rsp_timer = 0;
    always @(negedge clk_50m) begin
        if (rst) begin
            cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
            wait_cnt = 0; rsp_timer = 0;
        end else begin
            rsp_valid = 1'b0;
            rsp_nack = 1'b0;
            if (rsp_timer > 0) begin
                rsp_timer--;
                if (rsp_timer == 0) begin
                    rsp_valid = 1'b1;
                    if (ack_skip > 0) ack_skip--;
                    else if (nack_left > 0) begin
                        rsp_nack = 1'b1;
                        nack_left--;
                    end
                end
            end
            if (cmd_ready) begin
                cmd_ready = 1'b0;
                wait_cnt = 0;
                rsp_timer = 4;
            end else if (cmd_valid) begin
                if (wait_cnt >= ready_delay) cmd_ready = 1'b1;
                else wait_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted command, tracks stall stability.
    logic [23:0] stall_val = '0;
    bit stall_have = 0;
    always @(negedge clk_50m) begin
        #1;
        if (cmd_valid && cmd_ready) begin
            hs_count++;
            if (exp_q.size() == 0) check("unexpected_cmd", {cmd_dev, cmd_reg, cmd_data}, 0);
            else check("cmd", {cmd_dev, cmd_reg, cmd_data}, exp_q.pop_front());
            stall_have = 0;
        end else if (cmd_valid) begin
            stall_cycles++;
            if (stall_have && {cmd_reg, cmd_data} != stall_val) stab_bad++;
            stall_val = {cmd_reg, cmd_data};
            stall_have = 1;
        end
    end

    int t_mipi, t_cmd, t_end;

    task automatic pulse_start();
        @(negedge clk_50m);
        start = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
    endtask

    // Cycle indices count posedges after the one that sampled start.
    task automatic run_to_end();
        int n = 0;
        t_mipi = -1; t_cmd = -1; t_end = -1;
        hs_count = 0;
        pulse_start();
        while (!(done || error) && n < 20000) begin
            @(negedge clk_50m);
            n++;
            if (mipi_rst && t_mipi < 0) t_mipi = n;
            if (cmd_valid && t_cmd < 0) t_cmd = n;
        end
        if (done || error) t_end = n;
        else check("run_timeout", 0, 1);
        @(negedge clk_50m);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rom[i] = END_E;
        repeat (3) @(negedge clk_50m);
        check("reset_state", {mipi_rst, cmd_valid, busy, done, error, err_code, err_idx, tbl_addr},
              0);
        rst = 1'b0;
        repeat (2) @(negedge clk_50m);

        // Two writes then END.
        rom[0] = wr(16'h0100, 8'h00); rom[1] = wr(16'h0103, 8'h01); rom[2] = END_E;
        exp_q.push_back(exp_cmd(rom[0])); exp_q.push_back(exp_cmd(rom[1]));
        run_to_end();
        check("t1_mipi_rise", t_mipi, 1000);
        check("t1_first_cmd_window", (t_cmd >= 2002 && t_cmd <= 2003), 1);
        check("t1_status", {done, busy, error, mipi_rst}, 4'b1001);
        check("t1_handshakes", hs_count, 2);
        check("t1_queue_empty", exp_q.size(), 0);

        // Long cmd_ready stall.
        ready_delay = 50; stall_cycles = 0; stab_bad = 0;
        rom[0] = wr(16'h3000, 8'hAB); rom[1] = END_E;
        exp_q.push_back(exp_cmd(rom[0]));
        run_to_end();
        check("t2_stable", stab_bad, 0);
        check("t2_stall_ge50", stall_cycles >= 50, 1);
        check("t2_handshakes", hs_count, 1);
        check("t2_done", {done, error}, 2'b10);
        ready_delay = 0;

        // Entry 1 NACKed four times: one issue plus three retries, then error.
        rom[0] = wr(16'h0100, 8'h00); rom[1] = wr(16'h0103, 8'h01); rom[2] = END_E;
        ack_skip = 1; nack_left = 4;
        exp_q.push_back(exp_cmd(rom[0]));
        repeat (4) exp_q.push_back(exp_cmd(rom[1]));
        run_to_end();
        check("t3_handshakes", hs_count, 5);
        check("t3_status", {error, done, busy, mipi_rst}, 4'b1001);
        check("t3_err_code", err_code, 1);
        check("t3_err_idx", err_idx, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // DELAY 5 ms: decoded at cycle 2002, done expected 5000 +/- 3 later.
        rom[0] = dly(16'd5); rom[1] = END_E;
        run_to_end();
        check("t4_done_window", (t_end >= 6999 && t_end <= 7005), 1);
        check("t4_done", {done, error}, 2'b10);
        check("t4_no_cmds", hs_count, 0);

        // Asynchronous reset in the middle of the delay.
        pulse_start();
        repeat (4000) @(negedge clk_50m);
        check("t5_mid_delay", {busy, mipi_rst}, 2'b11);
        #2 rst = 1'b1;
        #1 check("t5_async_reset", {mipi_rst, busy, cmd_valid, done, error}, 0);
        @(negedge clk_50m);
        rst = 1'b0;
        repeat (5) @(negedge clk_50m);
        check("t5_idle", {busy, mipi_rst, done}, 0);

        // No END in a 4-entry table.
        rom[0] = wr(16'h0001, 8'h11); rom[1] = wr(16'h0002, 8'h22);
        rom[2] = dly(16'd0); rom[3] = wr(16'h0004, 8'h44);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(exp_cmd(rom[0])); exp_q.push_back(exp_cmd(rom[1]));
            exp_q.push_back(exp_cmd(rom[3]));
            run_to_end();
            check("t6_err", {error, done, err_code, err_idx}, {1'b1, 1'b0, 2'd2, 2'd3});
            check("t6_handshakes", hs_count, 3);
        end
        pulse_start();
        check("t6_restart", {mipi_rst, busy, error}, 3'b010);
        repeat (20) @(negedge clk_50m);
        rst = 1'b1;
        @(negedge clk_50m);
        rst = 1'b0;
        exp_q.delete();

        // Reserved opcode.
        rom[0] = wr(16'h0010, 8'h55); rom[1] = RSV_E;
        exp_q.push_back(exp_cmd(rom[0]));
        run_to_end();
        check("t7_err", {error, err_code, err_idx}, {1'b1, 2'd3, 2'd1});
        check("t7_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
